uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_sync.sv | 26 ++
 rtl/uart_rx.sv | 211 +++++++++++++++++++++
 tb/tb_uart_rx.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART receiver.
// Optional parity support is enabled with the macro UART_RX_PARITY_EN.
package uart_pkg;

   localparam int UART_DEFAULT_DATA_WIDTH = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
      ,
      PARITY = 3'd4
`endif
   } uart_rx_state_e;

   // Majority of three samples; one disturbed sample cannot flip the vote.
   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_sync.sv
// uart_sync: multi-flop synchronizer for an asynchronous single-bit input.
// Flops reset to RESET_VAL so an idle-high line does not look like an edge.
module uart_sync #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;

   // Shift the asynchronous input through the synchronizer chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= {STAGES{RESET_VAL}};
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver. Majority-votes three mid-bit samples, deserializes
// LSB first and hands bytes out through a single-entry valid/ready register.
// Define UART_RX_PARITY_EN to add a parity bit (cfg_parity_odd/rx_parity_err).
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH  = UART_DEFAULT_DATA_WIDTH,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx,
   input  logic                  baud_sample_6th,
   input  logic                  baud_sample_8th,
   input  logic                  baud_sample_10th,
   input  logic                  baud_sample_16th,
   output logic                  baud_clear,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   input  logic                  rx_ready,
   output logic                  rx_frame_err,
`ifdef UART_RX_PARITY_EN
   input  logic                  cfg_parity_odd,
   output logic                  rx_parity_err,
`endif
   output logic                  rx_overrun
);

   localparam int CNT_W = $clog2(DATA_WIDTH);

   uart_rx_state_e        state;
   uart_rx_state_e        next_state;
   logic                  rxs;
   logic                  rxs_prev;
   logic                  s6;
   logic                  s8;
   logic                  vote;
   logic                  fall;
   logic                  last_bit;
   logic [CNT_W-1:0]      bit_cnt;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic                  stop_eval;
   logic                  stop_good;
   logic                  load_byte;
   logic                  drop_byte;
   logic                  accept;
`ifdef UART_RX_PARITY_EN
   logic                  parity_bad;
`endif

   uart_sync #(
      .STAGES    (SYNC_STAGES),
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rxs)
   );

   assign fall     = rxs_prev & ~rxs;
   assign vote     = majority3(s6, s8, rxs);
   assign last_bit = (bit_cnt == CNT_W'(DATA_WIDTH - 1));
   assign accept   = rx_valid & rx_ready;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; each state reacts only to its own sample ticks.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (fall) next_state = START;
            else      next_state = IDLE;
         end
         START: begin
            if (baud_sample_10th && vote) next_state = IDLE;
            else if (baud_sample_16th)    next_state = DATA;
            else                          next_state = START;
         end
         DATA: begin
            if (baud_sample_16th && last_bit) begin
`ifdef UART_RX_PARITY_EN
               next_state = PARITY;
`else
               next_state = STOP;
`endif
            end else begin
               next_state = DATA;
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (baud_sample_16th) next_state = STOP;
            else                  next_state = PARITY;
         end
`endif
         STOP: begin
            // Leave at the 10th tick to keep margin for the next start edge.
            if (baud_sample_10th) next_state = IDLE;
            else                  next_state = STOP;
         end
         default: next_state = IDLE;
      endcase
   end

   // Output/decision decode from the current state and ticks.
   always_comb begin
      baud_clear = 1'b0;
      stop_eval  = 1'b0;
      if (state == IDLE) begin
         baud_clear = fall;
      end else if (state == STOP) begin
         stop_eval = baud_sample_10th;
      end else begin
         baud_clear = 1'b0;
         stop_eval  = 1'b0;
      end
   end

`ifdef UART_RX_PARITY_EN
   assign stop_good = stop_eval & vote & ~parity_bad;
`else
   assign stop_good = stop_eval & vote;
`endif
   assign load_byte = stop_good & (~rx_valid | rx_ready);
   assign drop_byte = stop_good & rx_valid & ~rx_ready;

   // Edge tracker and mid-bit sample capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rxs_prev <= 1'b1;
         s6       <= 1'b1;
         s8       <= 1'b1;
      end else begin
         rxs_prev <= rxs;
         if (baud_sample_6th) s6 <= rxs;
         if (baud_sample_8th) s8 <= rxs;
      end
   end

   // Bit counter and LSB-first deserializer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt   <= '0;
         shift_reg <= '0;
      end else begin
         if (state == START && baud_sample_16th) begin
            bit_cnt <= '0;
         end else if (state == DATA && baud_sample_16th && !last_bit) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
         end else begin
            bit_cnt <= bit_cnt;
         end
         if (state == DATA && baud_sample_10th) begin
            shift_reg[bit_cnt] <= vote;
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   // Parity check: expected bit is the data XOR, inverted for odd parity.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         parity_bad <= 1'b0;
      end else if (state == PARITY && baud_sample_10th) begin
         parity_bad <= vote ^ (^shift_reg) ^ cfg_parity_odd;
      end else begin
         parity_bad <= parity_bad;
      end
   end

   // Parity error pulse, suppressed by a framing error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_parity_err <= 1'b0;
      end else begin
         rx_parity_err <= stop_eval & vote & parity_bad;
      end
   end
`endif

   // Holding register with valid/ready handshake and error pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         rx_frame_err <= 1'b0;
         rx_overrun   <= 1'b0;
      end else begin
         rx_frame_err <= stop_eval & ~vote;
         rx_overrun   <= drop_byte;
         if (load_byte) begin
            rx_data  <= shift_reg;
            rx_valid <= 1'b1;
         end else if (accept) begin
            rx_valid <= 1'b0;
         end else begin
            rx_valid <= rx_valid;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx. A small baud model ticks every
// 10 clk (160 clk per bit) and restarts on baud_clear.
// Honors UART_RX_PARITY_EN when defined.
module tb_uart_rx;
   import uart_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx = 1'b1;
   logic       rx_ready = 1'b1;
   logic       baud_clear;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_frame_err;
   logic       rx_overrun;
   logic       t6, t8, t10, t16;
`ifdef UART_RX_PARITY_EN
   logic       cfg_parity_odd = 1'b0;
   logic       rx_parity_err;
`endif

   int n_chk = 0;
   int n_err = 0;
   int cnt = 0;
   int acc_n = 0;
   int frm_n = 0;
   int ovr_n = 0;
   int par_n = 0;
   logic [7:0] last_data = 8'h00;
   int exp_acc = 0;

   uart_rx #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
      .clk              (clk),
      .rst              (rst),
      .rx               (rx),
      .baud_sample_6th  (t6),
      .baud_sample_8th  (t8),
      .baud_sample_10th (t10),
      .baud_sample_16th (t16),
      .baud_clear       (baud_clear),
      .rx_data          (rx_data),
      .rx_valid         (rx_valid),
      .rx_ready         (rx_ready),
      .rx_frame_err     (rx_frame_err),
`ifdef UART_RX_PARITY_EN
      .cfg_parity_odd   (cfg_parity_odd),
      .rx_parity_err    (rx_parity_err),
`endif
      .rx_overrun       (rx_overrun)
   );

   always #5 clk = ~clk;

   // Baud model, updated on the falling edge to stay clear of the DUT edge.
   always @(negedge clk) begin
      if (baud_clear) cnt <= 0;
      else            cnt <= (cnt == 159) ? 0 : cnt + 1;
   end
   assign t6  = (cnt == 59);
   assign t8  = (cnt == 79);
   assign t10 = (cnt == 99);
   assign t16 = (cnt == 159);

   // Output monitor: counts accepted bytes and error pulses.
   always @(negedge clk) begin
      if (rx_valid && rx_ready) begin
         acc_n     <= acc_n + 1;
         last_data <= rx_data;
      end
      if (rx_frame_err) frm_n <= frm_n + 1;
      if (rx_overrun)   ovr_n <= ovr_n + 1;
`ifdef UART_RX_PARITY_EN
      if (rx_parity_err) par_n <= par_n + 1;
`endif
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         rx = 1'b1;
      end
   endtask

   // Send one frame; glitch_bit>=0 inverts that data bit near its 8th sample,
   // abort_bits>0 stops after that many bit periods.
   task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                             input logic par_flip, input int glitch_bit,
                             input int abort_bits);
      logic [11:0] bits;
      int nb;
      bits = 12'h000;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[i+1] = data[i];
      nb = 9;
`ifdef UART_RX_PARITY_EN
      bits[9] = (^data) ^ cfg_parity_odd ^ par_flip;
      nb = 10;
`endif
      bits[nb] = stop_bit;
      nb = nb + 1;
      for (int b = 0; b < nb; b++) begin
         if (abort_bits > 0 && b >= abort_bits) return;
         for (int t = 0; t < 160; t++) begin
            @(posedge clk);
            #1;
            if (glitch_bit >= 0 && b == glitch_bit + 1 && t >= 76 && t < 86)
               rx = ~bits[b];
            else
               rx = bits[b];
         end
      end
      idle(20);
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", rx_valid, 1'b0);
      chk("rst_data", rx_data, 8'h00);
      chk("rst_frame_err", rx_frame_err, 1'b0);
      chk("rst_overrun", rx_overrun, 1'b0);
      chk("rst_baud_clear", baud_clear, 1'b0);
      rst = 1'b0;
      idle(20);

      // Plain frame 0xA5
      send_frame(8'hA5, 1'b1, 1'b0, -1, 0);
      exp_acc++;
      chk("a5_count", acc_n, exp_acc);
      chk("a5_data", last_data, 8'hA5);
      chk("a5_frame_err", frm_n, 0);
      chk("a5_overrun", ovr_n, 0);

      // Start-bit glitch of 40 clk is rejected
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         rx = 1'b0;
      end
      idle(300);
      chk("glitch_count", acc_n, exp_acc);
      chk("glitch_frame_err", frm_n, 0);
      send_frame(8'h3C, 1'b1, 1'b0, -1, 0);
      exp_acc++;
      chk("after_glitch_count", acc_n, exp_acc);
      chk("after_glitch_data", last_data, 8'h3C);

      // Framing error, then recovery
      send_frame(8'h3C, 1'b0, 1'b0, -1, 0);
      chk("ferr_count", frm_n, 1);
      chk("ferr_no_byte", acc_n, exp_acc);
      chk("ferr_valid", rx_valid, 1'b0);
      send_frame(8'h55, 1'b1, 1'b0, -1, 0);
      exp_acc++;
      chk("after_ferr_count", acc_n, exp_acc);
      chk("after_ferr_data", last_data, 8'h55);
      chk("after_ferr_frame_err", frm_n, 1);

      // Overrun with consumer stalled
      @(posedge clk);
      #1;
      rx_ready = 1'b0;
      send_frame(8'h11, 1'b1, 1'b0, -1, 0);
      chk("hold_valid", rx_valid, 1'b1);
      chk("hold_data", rx_data, 8'h11);
      send_frame(8'h22, 1'b1, 1'b0, -1, 0);
      chk("ovr_count", ovr_n, 1);
      chk("ovr_data_kept", rx_data, 8'h11);
      chk("ovr_valid", rx_valid, 1'b1);
      chk("ovr_frame_err", frm_n, 1);
      @(posedge clk);
      #1;
      rx_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      exp_acc++;
      chk("drain_count", acc_n, exp_acc);
      chk("drain_data", last_data, 8'h11);
      chk("drain_valid", rx_valid, 1'b0);

      // Disturbed 8th sample of bit 3 is outvoted
      send_frame(8'h80, 1'b1, 1'b0, 3, 0);
      exp_acc++;
      chk("vote_count", acc_n, exp_acc);
      chk("vote_data", last_data, 8'h80);

`ifdef UART_RX_PARITY_EN
      // Even parity: 0x07 needs parity bit 1
      send_frame(8'h07, 1'b1, 1'b1, -1, 0);
      chk("par_err_count", par_n, 1);
      chk("par_err_no_byte", acc_n, exp_acc);
      send_frame(8'h07, 1'b1, 1'b0, -1, 0);
      exp_acc++;
      chk("par_ok_count", acc_n, exp_acc);
      chk("par_ok_data", last_data, 8'h07);
      chk("par_ok_err", par_n, 1);
`endif

      // Reset in the middle of a frame while a byte is held
      @(posedge clk);
      #1;
      rx_ready = 1'b0;
      send_frame(8'h5A, 1'b1, 1'b0, -1, 0);
      chk("pre_rst_valid", rx_valid, 1'b1);
      send_frame(8'hC3, 1'b1, 1'b0, -1, 4);
      rx  = 1'b1;
      rst = 1'b1;
      #1;
      chk("midrst_valid", rx_valid, 1'b0);
      chk("midrst_data", rx_data, 8'h00);
      chk("midrst_baud_clear", baud_clear, 1'b0);
      chk("midrst_state", dut.state, IDLE);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b0;
      rx_ready = 1'b1;
      idle(20);
      chk("midrst_no_ferr", frm_n, 1);
      send_frame(8'hF0, 1'b1, 1'b0, -1, 0);
      exp_acc++;
      chk("post_rst_count", acc_n, exp_acc);
      chk("post_rst_data", last_data, 8'hF0);
      chk("post_rst_overrun", ovr_n, 1);
      chk("post_rst_frame_err", frm_n, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
